// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic phase sequencer with all-red clearance; outputs registered with the state, en=0 freezes all timing.
// Optional pedestrian walk phase compiled in with TLC_PED_EN; without it ped_req is ignored and walk/ped_ack stay 0.
module traffic_phase_ctrl #(
    parameter int GREEN_CYC   = 8,
    parameter int YELLOW_CYC  = 3,
    parameter int RED_CLR_CYC = 2,
    parameter int PED_CYC     = 5,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5,
        PED  = 3'd6,
        BAD  = 3'd7
    } state_t;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_GRN = 3'b010;
    localparam logic [2:0] L_YEL = 3'b001;

    // Timer is loaded with duration-1 so a phase lasts exactly N enabled cycles.
    function automatic logic [CNT_W-1:0] load_val(input state_t s);
        logic [CNT_W-1:0] v;
        case (s)
            NS_G, EW_G: v = CNT_W'(GREEN_CYC - 1);
            NS_Y, EW_Y: v = CNT_W'(YELLOW_CYC - 1);
            PED:        v = CNT_W'(PED_CYC - 1);
            default:    v = CNT_W'(RED_CLR_CYC - 1);
        endcase
        return v;
    endfunction

    function automatic logic [2:0] ns_code(input state_t s);
        logic [2:0] c;
        case (s)
            NS_G:    c = L_GRN;
            NS_Y:    c = L_YEL;
            default: c = L_RED;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] ew_code(input state_t s);
        logic [2:0] c;
        case (s)
            EW_G:    c = L_GRN;
            EW_Y:    c = L_YEL;
            default: c = L_RED;
        endcase
        return c;
    endfunction

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] timer_q;
    logic [2:0]       ns_q;
    logic [2:0]       ew_q;
    logic             advance;

`ifdef TLC_PED_EN
    logic pending_q;
    logic dir_ew_q;
    logic walk_q;
    logic ped_ack_q;
    logic ped_go;
    logic enter_ped;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    // The illegal code recovers immediately, independent of the timer.
    assign advance = (en && (timer_q == '0)) || (state_q == BAD);

    always_comb begin
        state_d = state_q;
`ifdef TLC_PED_EN
        ped_go  = pending_q | ped_req;
`endif
        case (state_q)
            NS_G: state_d = NS_Y;
            NS_Y: state_d = AR1;
`ifdef TLC_PED_EN
            AR1:  state_d = ped_go ? PED : EW_G;
            AR2:  state_d = ped_go ? PED : NS_G;
            PED:  state_d = dir_ew_q ? EW_G : NS_G;
`else
            AR1:  state_d = EW_G;
            AR2:  state_d = NS_G;
`endif
            EW_G: state_d = EW_Y;
            EW_Y: state_d = AR2;
            default: state_d = AR2;
        endcase
    end

`ifdef TLC_PED_EN
    assign enter_ped = advance && (state_d == PED);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= AR2;
            timer_q   <= CNT_W'(RED_CLR_CYC - 1);
            ns_q      <= L_RED;
            ew_q      <= L_RED;
`ifdef TLC_PED_EN
            pending_q <= 1'b0;
            dir_ew_q  <= 1'b0;
            walk_q    <= 1'b0;
            ped_ack_q <= 1'b0;
`endif
        end else begin
            if (advance) begin
                state_q <= state_d;
                timer_q <= load_val(state_d);
                ns_q    <= ns_code(state_d);
                ew_q    <= ew_code(state_d);
            end else if (en) begin
                timer_q <= timer_q - 1'b1;
            end
`ifdef TLC_PED_EN
            if (advance) begin
                walk_q <= (state_d == PED);
            end
            ped_ack_q <= enter_ped;
            // Requests are latched even with en low, but never while walking.
            if (enter_ped) begin
                pending_q <= 1'b0;
                dir_ew_q  <= (state_q == AR1);
            end else if (ped_req && (state_q != PED)) begin
                pending_q <= 1'b1;
            end
`endif
        end
    end

    assign ns_light = ns_q;
    assign ew_light = ew_q;
    assign phase    = state_q;
`ifdef TLC_PED_EN
    assign walk     = walk_q;
    assign ped_ack  = ped_ack_q;
`else
    assign walk     = 1'b0;
    assign ped_ack  = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: a cycle model pushes expected outputs, popped after each edge.
module tb_traffic_phase_ctrl;

    localparam int G = 8;
    localparam int Y = 3;
    localparam int R = 2;
    localparam int P = 5;
`ifdef TLC_PED_EN
    localparam bit PED_ON = 1'b1;
`else
    localparam bit PED_ON = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    traffic_phase_ctrl #(
        .GREEN_CYC(G), .YELLOW_CYC(Y), .RED_CLR_CYC(R), .PED_CYC(P), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req),
        .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
        .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [10:0] sb_q[$];

    int m_st, m_cnt;
    bit m_pend, m_dir_ew, m_ack;

    int         cyc = 0;
    logic [2:0] obs_phase = 3'd7;
    logic [2:0] prev_phase = 3'd7;
    int         walk_cnt = 0;
    int         ack_cnt = 0;
    int         last_entry = 0;
    int         entry_period = 0;
    bit         entered = 1'b0;

    function automatic int dur(input int s);
        case (s)
            0, 3:    return G;
            1, 4:    return Y;
            6:       return P;
            default: return R;
        endcase
    endfunction

    function automatic logic [10:0] expv(input int s, input bit ack);
        logic [2:0] ns, ew;
        ns = 3'b100;
        ew = 3'b100;
        if (s == 0) ns = 3'b010;
        if (s == 1) ns = 3'b001;
        if (s == 3) ew = 3'b010;
        if (s == 4) ew = 3'b001;
        return {3'(s), ns, ew, (s == 6), ack};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        fails++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic model(input bit r, input bit e, input bit q);
        int  old_st, nxt;
        bit  go_ped;
        if (!r) begin
            m_st = 5; m_cnt = 0; m_pend = 0; m_dir_ew = 0; m_ack = 0;
            return;
        end
        old_st = m_st;
        m_ack  = 0;
        go_ped = 0;
        if (e) begin
            m_cnt++;
            if (m_cnt == dur(m_st)) begin
                m_cnt = 0;
                case (m_st)
                    0: nxt = 1;
                    1: nxt = 2;
                    2: nxt = (PED_ON && (m_pend || q)) ? 6 : 3;
                    3: nxt = 4;
                    4: nxt = 5;
                    5: nxt = (PED_ON && (m_pend || q)) ? 6 : 0;
                    default: nxt = m_dir_ew ? 3 : 0;
                endcase
                if (nxt == 6) begin
                    go_ped   = 1;
                    m_ack    = 1;
                    m_dir_ew = (m_st == 2);
                end
                m_st = nxt;
            end
        end
        if (go_ped) m_pend = 0;
        else if (PED_ON && q && old_st != 6) m_pend = 1;
    endtask

    task automatic step(input bit r, input bit e, input bit q);
        logic [10:0] got, exp;
        rst_n   = r;
        en      = e;
        ped_req = q;
        model(r, e, q);
        sb_q.push_back(expv(m_st, m_ack));
        @(posedge clk);
        #1;
        cyc++;
        got = {phase, ns_light, ew_light, walk, ped_ack};
        exp = sb_q.pop_front();
        chk($sformatf("cyc%0d", cyc), 32'(got), 32'(exp));
        prev_phase = obs_phase;
        obs_phase  = phase;
        walk_cnt  += int'(walk);
        ack_cnt   += int'(ped_ack);
        entered    = (obs_phase == 3'd0) && (prev_phase != 3'd0);
        if (entered) begin
            entry_period = cyc - last_entry;
            last_entry   = cyc;
        end
    endtask

    task automatic run_to_entry(input bit q, output int steps);
        steps = 0;
        do begin
            step(1'b1, 1'b1, q);
            steps++;
        end while (!entered && steps < 200);
        if (!entered) timeout("ns_g_entry");
    endtask

    task automatic wait_phase(input logic [2:0] p);
        int k = 0;
        while (obs_phase != p && k < 100) begin
            step(1'b1, 1'b1, 1'b0);
            k++;
        end
        if (obs_phase != p) timeout($sformatf("wait_phase%0d", p));
    endtask

    initial begin
        int n, span, k;

        // Reset and power-up clearance
        step(0, 0, 0);
        step(0, 0, 0);
        chk("rst_phase", 32'(phase), 32'd5);
        chk("rst_lamps", 32'({ns_light, ew_light}), 32'b100100);
        chk("rst_walk_ack", 32'({walk, ped_ack}), 32'd0);
        walk_cnt = 0; ack_cnt = 0;
        run_to_entry(0, n);
        chk("ar2_after_reset", 32'(n), 32'(R));

        // Base cycle
        run_to_entry(0, n);
        chk("period_base1", 32'(entry_period), 32'd26);
        run_to_entry(0, n);
        chk("period_base2", 32'(entry_period), 32'd26);
        chk("walk_base", 32'(walk_cnt), 32'd0);

        // Single request pulse in NS_G
        walk_cnt = 0; ack_cnt = 0;
        step(1, 1, 1);
        run_to_entry(0, n);
        chk("period_ped", 32'(entry_period), PED_ON ? 32'd31 : 32'd26);
        chk("walk_cycles", 32'(walk_cnt), PED_ON ? 32'(P) : 32'd0);
        chk("ack_pulses", 32'(ack_cnt), PED_ON ? 32'd1 : 32'd0);
        run_to_entry(0, n);
        chk("period_after_ped", 32'(entry_period), 32'd26);

        // Enable stall inside NS_G
        span = 1;
        step(1, 1, 0);
        if (obs_phase == 3'd0) span++;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            if (obs_phase == 3'd0) span++;
        end
        k = 0;
        while (obs_phase == 3'd0 && k < 50) begin
            step(1, 1, 0);
            if (obs_phase == 3'd0) span++;
            k++;
        end
        chk("ns_g_span_stall", 32'(span), 32'd12);

        // Reset with a request pending in EW_Y, en low on the reset edge
        wait_phase(3'd4);
        step(1, 1, 1);
        step(0, 0, 0);
        chk("midrst_phase", 32'(phase), 32'd5);
        chk("midrst_lamps", 32'({ns_light, ew_light, walk}), 32'b1001000);
        walk_cnt = 0; ack_cnt = 0;
        run_to_entry(0, n);
        chk("midrst_ar2_len", 32'(n), 32'(R));
        run_to_entry(0, n);
        chk("midrst_period", 32'(n), 32'd26);
        chk("midrst_no_ped", 32'(ack_cnt + walk_cnt), 32'd0);

        // Request held high continuously
        ack_cnt = 0;
        run_to_entry(1, n);
        chk("held_period1", 32'(entry_period), PED_ON ? 32'd36 : 32'd26);
        run_to_entry(1, n);
        chk("held_period2", 32'(entry_period), PED_ON ? 32'd36 : 32'd26);
        chk("held_acks", 32'(ack_cnt), PED_ON ? 32'd4 : 32'd0);
        run_to_entry(0, n);
        chk("released_period", 32'(entry_period), 32'd26);

`ifdef TLC_PED_EN
        // Requests raised only while walking are dropped
        step(1, 1, 1);
        wait_phase(3'd6);
        k = 0;
        while (obs_phase == 3'd6 && k < 20) begin
            step(1, 1, 1);
            k++;
        end
        ack_cnt = 0;
        run_to_entry(0, n);
        run_to_entry(0, n);
        chk("ped_only_req_period", 32'(n), 32'd26);
        chk("ped_only_req_acks", 32'(ack_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
